nprime0_rd_arbiter: RTL and testbench

Shares the single-port, read-only nprime0 constant ROM (32-bit words, 2-bit address, registered address and output) among several Montgomery-multiplier requesters. Round-robin arbitration with a valid/grant handshake, one accepted read per cycle, fully pipelined, and per-requester response strobes tagged through the fixed ROM read latency. Sits between the multiplier lanes and the nprime0 ROM instance in the ModExp datapath.

---
 rtl/nprime0_rd_arbiter.sv | 111 +++++++++++
 tb/tb_nprime0_rd_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nprime0_rd_arbiter.sv
// nprime0_rd_arbiter
// Round-robin read arbiter in front of the single-port nprime0 constant ROM.
// One read is accepted per cycle; a small tag pipeline follows each read
// through the ROM's fixed latency so the word can be returned to whichever
// multiplier lane asked for it, strictly in grant order.

module nprime0_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_WORDS  = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_data,
  input  logic [DATA_WIDTH-1:0]         mem_q,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = RD_LATENCY + 1;
  localparam logic [ADDR_WIDTH:0] NUM_WORDS_W = (ADDR_WIDTH+1)'(NUM_WORDS);

  logic [IDXW-1:0]       last_winner;
  logic [IDXW-1:0]       win_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_illegal;

  // Tag pipeline: stage 0 is the read just accepted, the last stage lines up with valid mem_q.
  logic [STAGES-1:0]     tag_valid;
  logic [IDXW-1:0]       tag_idx [STAGES];
  logic [STAGES-1:0]     tag_ill;

  // The ROM is never written.
  assign mem_data = '0;

  // Round-robin pick: scan from the requester after the last winner, wrapping around.
  always_comb begin
    logic [IDXW-1:0] cand;
    gnt     = '0;
    win_idx = '0;
    accept  = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(last_winner) + k) % NUM_REQ);
      if (!accept && req[cand]) begin
        accept    = 1'b1;
        gnt[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Address of the winning requester and whether it lies outside the populated words.
  always_comb begin
    sel_addr    = ADDR_WIDTH'(req_addr >> (win_idx * ADDR_WIDTH));
    sel_illegal = ({1'b0, sel_addr} >= NUM_WORDS_W);
  end

  // Arbitration pointer and ROM address move only on an accepted transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= IDXW'(NUM_REQ - 1);
      mem_address <= '0;
    end else if (accept) begin
      last_winner <= win_idx;
      mem_address <= sel_addr;
    end
  end

  // Shift tags through the read latency; a bubble enters whenever nothing is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_ill   <= '0;
      for (int s = 0; s < STAGES; s++) tag_idx[s] <= '0;
      busy      <= 1'b0;
    end else begin
      tag_valid <= {tag_valid[STAGES-2:0], accept};
      tag_ill   <= {tag_ill[STAGES-2:0], sel_illegal};
      tag_idx[0] <= win_idx;
      for (int s = 1; s < STAGES; s++) tag_idx[s] <= tag_idx[s-1];
      busy      <= (|tag_valid[STAGES-2:0]) | accept;
    end
  end

  // Return the ROM word to the tagged requester; data and error hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (tag_valid[STAGES-1]) begin
      rsp_valid <= NUM_REQ'(1) << tag_idx[STAGES-1];
      rsp_err   <= tag_ill[STAGES-1];
      rsp_data  <= tag_ill[STAGES-1] ? '0 : mem_q;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_nprime0_rd_arbiter.sv
// tb_nprime0_rd_arbiter
// Scoreboard bench: the stimulus process predicts grants from the round-robin
// rule and queues the expected response; a monitor on the falling edge pops
// and compares whenever rsp_valid shows up, and also checks busy and hold.

module tb_nprime0_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_WORDS  = 2;
  localparam int RD_LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  gnt;
  logic [1:0]  mem_address;
  logic [31:0] mem_data;
  logic [31:0] mem_q;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    int         idx;
    logic [1:0] addr;
    int         due;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          edge_cnt = 0;
  int          last_win = NUM_REQ - 1;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  bit          mon_on = 1'b0;

  logic [31:0] rom [4];
  logic [1:0]  rom_addr_q;

  nprime0_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_WORDS(NUM_WORDS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .mem_address(mem_address), .mem_data(mem_data), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Edge counter used to time responses.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // ROM model: registered address then registered output; unpopulated words hold junk.
  initial begin
    rom[0] = 32'h13572468;
    rom[1] = 32'h89ABCDEF;
    rom[2] = 32'hDEAD0002;
    rom[3] = 32'hDEAD0003;
  end

  always @(posedge clock) begin
    rom_addr_q <= mem_address;
    mem_q      <= rom[rom_addr_q];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Round-robin reference: first active requester after the previous winner.
  function automatic int model_pick(input logic [3:0] r, input int lw);
    int order [4];
    for (int k = 0; k < 4; k++) order[k] = (lw + 1 + k) % 4;
    foreach (order[k]) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  // One clock cycle of stimulus: drive, predict the grant, queue the response.
  task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [7:0] a, output int gidx);
    exp_t e;
    reset    = rst;
    req      = r;
    req_addr = a;
    gidx     = -1;
    @(negedge clock);
    if (!rst) begin
      gidx = model_pick(r, last_win);
      checkOutput("gnt", {28'b0, gnt}, (gidx < 0) ? 32'h0 : (32'h1 << gidx));
      if (gidx >= 0) begin
        e.idx  = gidx;
        e.addr = 2'(a >> (2 * gidx));
        e.due  = edge_cnt + 4;
        sb.push_back(e);
        last_win = gidx;
      end
    end
    @(posedge clock);
    #1;
    if (rst) begin
      sb.delete();
      last_win  = NUM_REQ - 1;
      last_data = '0;
      last_err  = 1'b0;
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_mem_address", {30'b0, mem_address}, 32'h0);
    checkOutput("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_gnt_idle", {28'b0, gnt}, 32'h0);
    checkOutput("mem_data_zero", mem_data, 32'h0);
  endtask

  // Monitor: pop and compare on every response, otherwise check hold and missing responses.
  always @(negedge clock) begin
    if (mon_on) begin
      exp_t        e;
      logic        exp_busy;
      logic        ill;
      logic [31:0] expd;
      exp_busy = 1'b0;
      foreach (sb[i]) if (sb[i].due > edge_cnt && sb[i].due <= edge_cnt + 3) exp_busy = 1'b1;
      checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (rsp_valid != 4'b0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", {28'b0, rsp_valid}, 32'h0);
        end else begin
          e    = sb.pop_front();
          ill  = (int'(e.addr) >= NUM_WORDS);
          expd = ill ? 32'h0 : rom[e.addr];
          checkOutput("rsp_valid", {28'b0, rsp_valid}, 32'h1 << e.idx);
          checkOutput("rsp_data", rsp_data, expd);
          checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, ill});
          checkOutput("rsp_edge", edge_cnt, e.due);
          last_data = expd;
          last_err  = ill;
        end
      end else begin
        checkOutput("rsp_data_hold", rsp_data, last_data);
        checkOutput("rsp_err_hold", {31'b0, rsp_err}, {31'b0, last_err});
        if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL rsp_missing: rsp_valid 0 at edge %0d, expected requester %0d", edge_cnt, e.idx);
        end
      end
    end
  end

  initial begin
    int         g;
    logic [3:0] pend;
    logic [7:0] paddr;

    repeat (3) applyStimulus(1'b1, 4'b0, 8'h0, g);
    checkResetState();
    mon_on = 1'b1;

    $display("[TB] single read");
    applyStimulus(1'b0, 4'b0001, 8'h01, g);
    repeat (5) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] all four requesting");
    repeat (12) applyStimulus(1'b0, 4'b1111, 8'b01_00_01_00, g);
    repeat (5) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] illegal address");
    applyStimulus(1'b0, 4'b0100, 8'b00_11_00_00, g);
    applyStimulus(1'b0, 4'b0001, 8'h01, g);
    repeat (5) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] fairness");
    repeat (20) applyStimulus(1'b0, {1'($urandom_range(0, 1)), 3'b010}, 8'b00_00_01_00, g);
    repeat (5) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] back-to-back");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0001, {6'b0, 2'(i % 2)}, g);
    repeat (6) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] random traffic");
    pend  = '0;
    paddr = '0;
    repeat (300) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          paddr   = (paddr & ~(8'h3 << (2 * i))) | (8'($urandom_range(0, 3)) << (2 * i));
        end
      end
      applyStimulus(1'b0, pend, paddr, g);
      if (g >= 0) pend = pend & ~(4'b1 << g);
    end
    repeat (6) applyStimulus(1'b0, 4'b0, 8'h0, g);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b0, 4'b0001, 8'h01, g);
    applyStimulus(1'b0, 4'b0010, 8'h00, g);
    applyStimulus(1'b0, 4'b0100, 8'h10, g);
    repeat (2) applyStimulus(1'b1, 4'b1111, 8'h0, g);
    req = 4'b0;
    #1;
    checkResetState();
    applyStimulus(1'b0, 4'b1111, 8'b01_01_01_01, g);
    repeat (8) applyStimulus(1'b0, 4'b0, 8'h0, g);

    checkOutput("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
